// File: rtl/iob_master_ctrl.sv
// I/O-bus master controller: runs one MC68000-style async bus cycle on the C8M I/O bus per
// IOREQ/IOACT handshake, with nDTACK/nBERR/timeout termination, 6800 nVPA cycles and E clock.
module iob_master_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned E_LOW   = 6,
  parameter int unsigned E_HIGH  = 4
) (
  input  logic CLK,
  input  logic Reset,
  input  logic C8M,
  input  logic IOREQ,
  input  logic IORW,
  input  logic IOL,
  input  logic IOU,
  input  logic nDTACK,
  input  logic nBERR,
  input  logic nVPA,
  output logic IOACT,
  output logic IOBERR,
  output logic nAS,
  output logic nLDS,
  output logic nUDS,
  output logic nRW,
  output logic nDoutOE,
  output logic nDinLE,
  output logic E
);

  localparam int unsigned EPeriod = E_LOW + E_HIGH;
  localparam int unsigned ECntW   = $clog2(EPeriod);

  typedef enum logic [2:0] {
    StIdle, StArm, StS2, StWait, StVpa, StEnd, StRec, StHold
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       c8m_sync_q, c8m_sync_d;
  logic [1:0]       dtack_sync_q, dtack_sync_d;
  logic [1:0]       berr_sync_q, berr_sync_d;
  logic [1:0]       vpa_sync_q, vpa_sync_d;
  logic             ioreq_sync_q, ioreq_sync_d;
  logic [ECntW-1:0] e_cnt_q, e_cnt_d;
  logic             e_q, e_d;
  logic [7:0]       to_cnt_q, to_cnt_d;
  logic             rw_q, rw_d;
  logic             lds_req_q, lds_req_d;
  logic             uds_req_q, uds_req_d;
  logic             ioact_q, ioact_d;
  logic             ioberr_q, ioberr_d;
  logic             nas_q, nas_d;
  logic             nlds_q, nlds_d;
  logic             nuds_q, nuds_d;
  logic             nrw_q, nrw_d;
  logic             ndoutoe_q, ndoutoe_d;
  logic             ndinle_q, ndinle_d;

  logic c8m_fall;
  logic e_wrap;

  // Bit 2 is an extra stage behind the 2-flop synchroniser, used only for edge detection.
  assign c8m_fall = c8m_sync_q[2] & ~c8m_sync_q[1];
  assign e_wrap   = (e_cnt_q == ECntW'(EPeriod - 1));

  always_comb begin
    state_d      = state_q;
    c8m_sync_d   = {c8m_sync_q[1:0], C8M};
    dtack_sync_d = {dtack_sync_q[0], nDTACK};
    berr_sync_d  = {berr_sync_q[0], nBERR};
    vpa_sync_d   = {vpa_sync_q[0], nVPA};
    ioreq_sync_d = IOREQ;
    e_cnt_d      = e_cnt_q;
    to_cnt_d     = to_cnt_q;
    rw_d         = rw_q;
    lds_req_d    = lds_req_q;
    uds_req_d    = uds_req_q;
    ioact_d      = ioact_q;
    ioberr_d     = ioberr_q;
    nas_d        = nas_q;
    nlds_d       = nlds_q;
    nuds_d       = nuds_q;
    nrw_d        = nrw_q;
    ndoutoe_d    = ndoutoe_q;
    ndinle_d     = ndinle_q;

    if (c8m_fall) begin
      e_cnt_d = e_wrap ? '0 : e_cnt_q + 1'b1;
    end
    e_d = (e_cnt_d >= ECntW'(E_LOW));

    unique case (state_q)
      StIdle: begin
        if (ioreq_sync_q) begin
          ioact_d   = 1'b1;
          rw_d      = IORW;
          lds_req_d = IOL;
          uds_req_d = IOU;
          state_d   = StArm;
        end
      end
      StArm: begin
        if (c8m_fall) begin
          nas_d     = 1'b0;
          nrw_d     = rw_q;
          ndoutoe_d = rw_q;
          to_cnt_d  = '0;
          ioberr_d  = 1'b0;
          state_d   = StS2;
        end
      end
      StS2: begin
        if (c8m_fall) begin
          nlds_d  = ~lds_req_q;
          nuds_d  = ~uds_req_q;
          state_d = StWait;
        end
      end
      StWait: begin
        // Bus error outranks DTACK; VPA only when neither terminates the cycle.
        if (c8m_fall) begin
          if (!berr_sync_q[1]) begin
            ioberr_d = 1'b1;
            state_d  = StEnd;
          end else if (!dtack_sync_q[1]) begin
            state_d = StEnd;
          end else if (!vpa_sync_q[1]) begin
            state_d = StVpa;
          end else if (to_cnt_q == 8'(TIMEOUT)) begin
            ioberr_d = 1'b1;
            state_d  = StEnd;
          end else begin
            to_cnt_d = to_cnt_q + 8'd1;
          end
        end
      end
      StVpa: begin
        if (c8m_fall && e_wrap) begin
          state_d = StEnd;
        end
      end
      StEnd: begin
        if (c8m_fall) begin
          nas_d    = 1'b1;
          nlds_d   = 1'b1;
          nuds_d   = 1'b1;
          ndinle_d = ~(rw_q & ~ioberr_q);
          state_d  = StRec;
        end
      end
      StRec: begin
        ndinle_d  = 1'b1;
        ndoutoe_d = 1'b1;
        nrw_d     = 1'b1;
        ioact_d   = 1'b0;
        state_d   = StHold;
      end
      StHold: begin
        // A request left high from the finished cycle must drop before another can start.
        if (!ioreq_sync_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= StIdle;
      c8m_sync_q   <= '0;
      dtack_sync_q <= 2'b11;
      berr_sync_q  <= 2'b11;
      vpa_sync_q   <= 2'b11;
      ioreq_sync_q <= 1'b0;
      e_cnt_q      <= '0;
      e_q          <= 1'b0;
      to_cnt_q     <= '0;
      rw_q         <= 1'b1;
      lds_req_q    <= 1'b0;
      uds_req_q    <= 1'b0;
      ioact_q      <= 1'b0;
      ioberr_q     <= 1'b0;
      nas_q        <= 1'b1;
      nlds_q       <= 1'b1;
      nuds_q       <= 1'b1;
      nrw_q        <= 1'b1;
      ndoutoe_q    <= 1'b1;
      ndinle_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      c8m_sync_q   <= c8m_sync_d;
      dtack_sync_q <= dtack_sync_d;
      berr_sync_q  <= berr_sync_d;
      vpa_sync_q   <= vpa_sync_d;
      ioreq_sync_q <= ioreq_sync_d;
      e_cnt_q      <= e_cnt_d;
      e_q          <= e_d;
      to_cnt_q     <= to_cnt_d;
      rw_q         <= rw_d;
      lds_req_q    <= lds_req_d;
      uds_req_q    <= uds_req_d;
      ioact_q      <= ioact_d;
      ioberr_q     <= ioberr_d;
      nas_q        <= nas_d;
      nlds_q       <= nlds_d;
      nuds_q       <= nuds_d;
      nrw_q        <= nrw_d;
      ndoutoe_q    <= ndoutoe_d;
      ndinle_q     <= ndinle_d;
    end
  end

  assign IOACT   = ioact_q;
  assign IOBERR  = ioberr_q;
  assign nAS     = nas_q;
  assign nLDS    = nlds_q;
  assign nUDS    = nuds_q;
  assign nRW     = nrw_q;
  assign nDoutOE = ndoutoe_q;
  assign nDinLE  = ndinle_q;
  assign E       = e_q;

endmodule

// File: tb/tb_iob_master_ctrl.sv
// Scoreboard bench for iob_master_ctrl: expected bus-cycle outcomes are queued at request time
// and compared by a cycle monitor when IOACT drops.
module tb_iob_master_ctrl;

  localparam int unsigned ELow  = 6;
  localparam int unsigned EHigh = 4;

  localparam int RespNone  = 0;
  localparam int RespTied  = 1;
  localparam int RespDelay = 2;
  localparam int RespVpa   = 3;
  localparam int RespBerr  = 4;

  logic CLK, Reset, C8M, IOREQ, IORW, IOL, IOU, nDTACK, nBERR, nVPA;
  logic IOACT, IOBERR, nAS, nLDS, nUDS, nRW, nDoutOE, nDinLE, E;

  iob_master_ctrl #(.TIMEOUT(255), .E_LOW(ELow), .E_HIGH(EHigh)) dut (
    .CLK(CLK), .Reset(Reset), .C8M(C8M), .IOREQ(IOREQ), .IORW(IORW), .IOL(IOL), .IOU(IOU),
    .nDTACK(nDTACK), .nBERR(nBERR), .nVPA(nVPA), .IOACT(IOACT), .IOBERR(IOBERR), .nAS(nAS),
    .nLDS(nLDS), .nUDS(nUDS), .nRW(nRW), .nDoutOE(nDoutOE), .nDinLE(nDinLE), .E(E)
  );

  initial begin CLK = 1'b0; forever #5 CLK = ~CLK; end
  initial begin C8M = 1'b0; forever #62 C8M = ~C8M; end

  typedef struct {
    bit          rd;
    bit          l;
    bit          u;
    bit          berr;
    int unsigned periods;  // 0 = nAS width not checked
    int unsigned dinle;
  } exp_t;

  exp_t sb_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int          resp_mode = RespNone;
  int unsigned dtack_dly = 4;
  int unsigned c8m_falls = 0;
  int unsigned nas_falls = 0;
  int unsigned nas_rise_mark = 0;
  int unsigned e_fall_mark = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge C8M) c8m_falls++;
  always @(negedge nAS) nas_falls++;
  always @(posedge nAS) nas_rise_mark = c8m_falls;
  always @(negedge E) e_fall_mark = c8m_falls;

  // Bus slave model: single driver of the response lines.
  initial begin
    bit          nas_seen;
    int unsigned mark;
    nDTACK = 1'b1; nBERR = 1'b1; nVPA = 1'b1;
    nas_seen = 1'b0; mark = 0;
    forever begin
      @(posedge CLK); #1;
      if (nAS !== 1'b0) begin
        nDTACK = (resp_mode == RespTied) ? 1'b0 : 1'b1;
        nBERR = 1'b1; nVPA = 1'b1; nas_seen = 1'b0;
      end else begin
        if (!nas_seen) begin nas_seen = 1'b1; mark = c8m_falls; end
        case (resp_mode)
          RespDelay: if (c8m_falls - mark >= dtack_dly) nDTACK = 1'b0;
          RespVpa:   nVPA = 1'b0;
          RespBerr:  begin nBERR = 1'b0; nDTACK = 1'b0; end
          default:   ;
        endcase
      end
    end
  end

  // Cycle monitor: observes one IOACT window and compares against the scoreboard head.
  bit          mon_active = 1'b0;
  int unsigned nas_clks, dinle_clks, rw_obs, oe_obs, oe_last;
  bit          saw_l, saw_u;
  always @(negedge CLK) begin
    exp_t ex;
    if (Reset) begin
      mon_active = 1'b0;
    end else begin
      if (IOACT && !mon_active) begin
        mon_active = 1'b1; nas_clks = 0; dinle_clks = 0; rw_obs = 2; oe_obs = 2; oe_last = 2;
        saw_l = 1'b0; saw_u = 1'b0;
      end
      if (mon_active) begin
        if (IOACT) begin
          if (!nAS) begin
            nas_clks++;
            if (!nLDS) saw_l = 1'b1;
            if (!nUDS) saw_u = 1'b1;
            rw_obs = nRW; oe_obs = nDoutOE;
          end
          if (!nDinLE) dinle_clks++;
          oe_last = nDoutOE;
        end else begin
          mon_active = 1'b0;
          check_eq("sb_nonempty", (sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            ex = sb_q.pop_front();
            check_eq("ioberr", IOBERR, ex.berr);
            check_eq("nrw_during", rw_obs, ex.rd);
            check_eq("ndoutoe_during", oe_obs, ex.rd);
            check_eq("ndoutoe_until_end", oe_last, ex.rd);
            check_eq("release_oe_rw", {nDoutOE, nRW, nAS, nLDS, nUDS}, 5'b11111);
            check_eq("lds_low", saw_l, ex.l);
            check_eq("uds_low", saw_u, ex.u);
            check_eq("dinle_clks", dinle_clks, ex.dinle);
            if (ex.periods != 0) check_eq("nas_periods", (nas_clks * 10 + 62) / 124, ex.periods);
          end
        end
      end
    end
  end

  task automatic start_req(input bit rd, input bit l, input bit u);
    @(posedge CLK); #1;
    IORW = rd; IOL = l; IOU = u; IOREQ = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check_eq("ioact_lat1", IOACT, 0);
    @(negedge CLK);
    check_eq("ioact_lat2", IOACT, 1);
  endtask

  task automatic run_cycle(input bit rd, input bit l, input bit u, input int mode,
                           input bit berr, input int unsigned per, input int unsigned dinle,
                           input bit keep);
    exp_t ex;
    resp_mode = mode;
    ex.rd = rd; ex.l = l; ex.u = u; ex.berr = berr; ex.periods = per; ex.dinle = dinle;
    sb_q.push_back(ex);
    start_req(rd, l, u);
    for (int i = 0; i < 6000 && IOACT; i++) @(negedge CLK);
    check_eq("ioact_drop", IOACT, 0);
    @(posedge CLK); #1;
    if (!keep) IOREQ = 1'b0;
    repeat (4) @(posedge CLK);
  endtask

  task automatic wait_e(input logic v);
    for (int i = 0; i < 400 && E !== v; i++) @(negedge CLK);
  endtask

  initial begin
    int unsigned r1, f1, r2, mark;
    Reset = 1'b1; IOREQ = 1'b0; IORW = 1'b1; IOL = 1'b0; IOU = 1'b0;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    check_eq("reset_outs", {IOACT, IOBERR, nAS, nLDS, nUDS, nRW, nDoutOE, nDinLE, E},
             9'b001111110);
    @(posedge CLK); #1 Reset = 1'b0;

    // E clock shape
    wait_e(1'b1); r1 = c8m_falls;
    wait_e(1'b0); f1 = c8m_falls;
    wait_e(1'b1); r2 = c8m_falls;
    check_eq("e_high", f1 - r1, EHigh);
    check_eq("e_low", r2 - f1, ELow);

    // read, DTACK tied low, both strobes
    run_cycle(1, 1, 1, RespTied, 0, 3, 1, 0);
    // write, upper byte only, DTACK late
    dtack_dly = 4;
    run_cycle(0, 0, 1, RespDelay, 0, 0, 0, 0);
    // 6800 cycle: strobes end just after E falls
    run_cycle(1, 1, 0, RespVpa, 0, 0, 1, 0);
    check_eq("vpa_end_after_e_fall",
             (nas_rise_mark >= e_fall_mark) && (nas_rise_mark - e_fall_mark <= 1), 1);
    // no response: timeout
    run_cycle(1, 1, 1, RespNone, 1, 258, 0, 0);
    // BERR and DTACK together
    run_cycle(1, 1, 1, RespBerr, 1, 3, 0, 0);
    // no byte strobes requested; also clears IOBERR from the previous cycle
    run_cycle(1, 0, 0, RespTied, 0, 3, 1, 0);

    // reset in WAIT
    resp_mode = RespNone;
    start_req(1, 1, 1);
    for (int i = 0; i < 200 && nAS; i++) @(negedge CLK);
    mark = c8m_falls;
    for (int i = 0; i < 200 && (c8m_falls - mark < 5); i++) @(negedge CLK);
    @(posedge CLK); #1 Reset = 1'b1; IOREQ = 1'b0;
    @(posedge CLK); #1;
    check_eq("reset_in_wait", {IOACT, IOBERR, nAS, nLDS, nUDS, nRW, nDoutOE, nDinLE, E},
             9'b001111110);
    Reset = 1'b0;
    repeat (4) @(posedge CLK);

    // IOREQ held high after completion must not restart
    run_cycle(1, 1, 1, RespTied, 0, 3, 1, 1);
    mark = nas_falls;
    repeat (300) @(negedge CLK);
    check_eq("hold_no_second_as", nas_falls - mark, 0);
    check_eq("hold_ioact_low", IOACT, 0);
    @(posedge CLK); #1 IOREQ = 1'b0;
    repeat (5) @(posedge CLK);
    run_cycle(0, 1, 1, RespTied, 0, 3, 0, 0);
    check_eq("hold_restart", nas_falls - mark, 1);

    check_eq("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
